// File: rtl/beam_trigger_gen.sv
// beam_trigger_gen: masks and coalesces per-beam primary hits into timestamped events on valid/ready.
// Define BEAM_SCALERS_EN to build per-beam secondary-hit scalers and their read port.
module beam_trigger_gen #(
  parameter int NBEAMS = 48,
  parameter int WINDOW_LEN = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2*NBEAMS-1:0]   trigger_i,
  input  logic [NBEAMS-1:0]     mask_i,
  input  logic                  mask_wr_i,
  input  logic [15:0]           holdoff_i,
  output logic                  trig_valid_o,
  input  logic                  trig_ready_i,
  output logic [NBEAMS-1:0]     trig_beams_o,
  output logic [31:0]           trig_time_o,
  output logic [15:0]           missed_o
`ifdef BEAM_SCALERS_EN
  ,
  input  logic [5:0]            scaler_addr_i,
  input  logic                  scaler_clr_i,
  output logic [15:0]           scaler_o
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_PRES = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
  logic [NBEAMS-1:0] r_prim;
  logic [NBEAMS-1:0] r_mask;
  logic [NBEAMS-1:0] r_beams;
  logic [31:0]       r_tcnt;
  logic [31:0]       r_time;
  logic [1:0]        r_state;
  logic [3:0]        r_wcnt;
  logic [15:0]       r_hcnt;
  logic [15:0]       r_missed;
  logic [NBEAMS-1:0] w_hit;
  logic              w_any;
  logic              w_drop;
  assign w_hit  = r_prim & ~r_mask;
  assign w_any  = |w_hit;
  assign w_drop = (r_state == S_PRES) || (r_state == S_HOLD);
  assign trig_valid_o = r_state == S_PRES;
  assign trig_beams_o = r_beams;
  assign trig_time_o  = r_time;
  assign missed_o     = r_missed;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prim   <= '0;
      r_mask   <= '1;
      r_beams  <= '0;
      r_tcnt   <= '0;
      r_time   <= '0;
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_hcnt   <= '0;
      r_missed <= '0;
    end else begin
      r_prim <= trigger_i[NBEAMS-1:0];
      r_tcnt <= r_tcnt + 32'd1;
      if (mask_wr_i) r_mask <= mask_i;
      if (w_drop && w_any && ~&r_missed) r_missed <= r_missed + 16'd1;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_beams <= w_hit;
          r_time  <= r_tcnt;
          r_wcnt  <= 4'(WINDOW_LEN > 1 ? WINDOW_LEN - 2 : 0);
          r_state <= WINDOW_LEN == 1 ? S_PRES : S_ACC;
        end
        S_ACC: begin
          r_beams <= r_beams | w_hit;
          r_wcnt  <= r_wcnt - 4'd1;
          if (r_wcnt == 4'd0) r_state <= S_PRES;
        end
        S_PRES: if (trig_ready_i) begin
          r_hcnt  <= holdoff_i;
          r_state <= holdoff_i == 16'd0 ? S_IDLE : S_HOLD;
        end
        default: begin
          r_hcnt <= r_hcnt - 16'd1;
          if (r_hcnt == 16'd1) r_state <= S_IDLE;
        end
      endcase
    end
  end
`ifdef BEAM_SCALERS_EN
  logic [NBEAMS-1:0] r_sec;
  logic [15:0]       r_scal [NBEAMS];
  logic [15:0]       r_scaler;
  assign scaler_o = r_scaler;
  // clear wins over a coincident increment
  always_ff @(posedge clk_i) begin
    r_sec <= rst_i ? '0 : trigger_i[2*NBEAMS-1:NBEAMS];
    for (int b = 0; b < NBEAMS; b++)
      r_scal[b] <= (rst_i || scaler_clr_i) ? 16'd0 : r_scal[b] + 16'(r_sec[b] && ~&r_scal[b]);
    r_scaler <= (rst_i || 32'(scaler_addr_i) >= NBEAMS) ? 16'd0 : r_scal[scaler_addr_i];
  end
`else
  logic w_unused;
  assign w_unused = ^trigger_i[2*NBEAMS-1:NBEAMS];
`endif
endmodule

// File: tb/tb_beam_trigger_gen.sv
// tb_beam_trigger_gen: scoreboard bench; expected events are queued at stimulus time and matched on valid.
module tb_beam_trigger_gen;
  localparam int NB = 48;
  localparam int WL = 4;
  typedef struct {
    logic [NB-1:0] beams;
    logic [31:0]   tim;
    longint        vcyc;
  } ev_t;
  logic          clk = 1'b0;
  logic          rst_i;
  logic [2*NB-1:0] trig;
  logic [NB-1:0] mask;
  logic          mask_wr;
  logic [15:0]   holdoff;
  logic          valid;
  logic          ready;
  logic [NB-1:0] beams;
  logic [31:0]   tim;
  logic [15:0]   missed;
`ifdef BEAM_SCALERS_EN
  logic [5:0]    saddr;
  logic          sclr;
  logic [15:0]   scaler;
`endif
  ev_t    exp_q[$];
  longint cyc = 0;
  int     n_chk = 0;
  int     n_fail = 0;
  logic   prev_v = 1'b0;
  beam_trigger_gen #(.NBEAMS(NB), .WINDOW_LEN(WL)) dut (
    .clk_i(clk), .rst_i(rst_i), .trigger_i(trig), .mask_i(mask), .mask_wr_i(mask_wr),
    .holdoff_i(holdoff), .trig_valid_o(valid), .trig_ready_i(ready), .trig_beams_o(beams),
    .trig_time_o(tim), .missed_o(missed)
`ifdef BEAM_SCALERS_EN
    , .scaler_addr_i(saddr), .scaler_clr_i(sclr), .scaler_o(scaler)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_i ? 0 : cyc + 1;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [NB-1:0] b, input longint t0, input longint v0);
    ev_t e;
    e.beams = b;
    e.tim = 32'(t0);
    e.vcyc = v0;
    exp_q.push_back(e);
  endtask
  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    if (!rst_i && valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 64'(valid), 64'd0);
      else begin
        if (!prev_v) check("valid_cycle", 64'(cyc), 64'(exp_q[0].vcyc));
        check("beams", 64'(beams), 64'(exp_q[0].beams));
        check("time", 64'(tim), 64'(exp_q[0].tim));
        if (ready) void'(exp_q.pop_front());
      end
    end
    prev_v = valid && !rst_i;
  end
  initial begin
    longint t;
    logic [15:0] m0;
    rst_i = 1'b1; trig = '0; mask = '0; mask_wr = 1'b0; holdoff = '0; ready = 1'b0;
`ifdef BEAM_SCALERS_EN
    saddr = 6'd3; sclr = 1'b0;
`endif
    step(3);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_beams", 64'(beams), 64'd0);
    check("rst_time", 64'(tim), 64'd0);
    check("rst_missed", 64'(missed), 64'd0);
`ifdef BEAM_SCALERS_EN
    check("rst_scaler", 64'(scaler), 64'd0);
`endif
    rst_i = 1'b0;
    // all beams masked out of reset
    trig[NB-1:0] = '1;
    step(8);
    check("masked_valid", 64'(valid), 64'd0);
    check("masked_missed", 64'(missed), 64'd0);
    trig = '0;
    mask = {{(NB-1){1'b1}}, 1'b0}; mask_wr = 1'b1;
    step();
    mask_wr = 1'b0; ready = 1'b1;
    trig[NB-1:0] = '1;
    push(48'h1, cyc + 1, cyc + WL + 1);
    step();
    trig = '0;
    drain(30);
    // single pulse on beam 5
    mask = '0; mask_wr = 1'b1;
    step();
    mask_wr = 1'b0;
    step();
    trig[5] = 1'b1;
    push(48'h20, cyc + 1, cyc + WL + 1);
    step();
    trig = '0;
    drain(30);
    step(2);
    // window edges: beams 2|40 at N and N+3, beam 7 at N+4 (missed) and N+5 (new event)
    m0 = missed; t = cyc;
    trig[2] = 1'b1; trig[40] = 1'b1;
    push((48'h1 << 2) | (48'h1 << 40), t + 1, t + WL + 1);
    push(48'h1 << 7, t + 6, t + 6 + WL);
    step(); trig = '0;
    step(2); trig[2] = 1'b1; trig[40] = 1'b1;
    step(); trig = '0; trig[7] = 1'b1;
    step(2); trig = '0;
    drain(40);
    check("missed_edge", 64'(missed), 64'(m0 + 16'd1));
    step(2);
    // ready low for 10 valid cycles, then accept with holdoff 3
    ready = 1'b0; m0 = missed; t = cyc;
    trig[0] = 1'b1;
    push(48'h1, t + 1, t + WL + 1);
    step(15);
    check("missed_hold", 64'(missed), 64'(m0 + 16'd10));
    check("valid_hold", 64'(valid), 64'd1);
    push(48'h1, t + 19, t + 19 + WL);
    ready = 1'b1; holdoff = 16'd3;
    step(); holdoff = 16'd0;
    step(3); trig = '0;
    drain(40);
    check("missed_holdoff", 64'(missed), 64'(m0 + 16'd14));
    step(2);
    // reset while presenting discards the event
    ready = 1'b0; t = cyc;
    trig[9] = 1'b1;
    push(48'h1 << 9, t + 1, t + WL + 1);
    step(WL + 1);
    check("pre_rst_valid", 64'(valid), 64'd1);
    rst_i = 1'b1;
    step();
    check("post_rst_valid", 64'(valid), 64'd0);
    check("post_rst_missed", 64'(missed), 64'd0);
    check("post_rst_beams", 64'(beams), 64'd0);
    exp_q.delete();
    rst_i = 1'b0;
    step(10);
    check("post_rst_masked", 64'(valid), 64'd0);
    check("post_rst_missed2", 64'(missed), 64'd0);
    trig = '0;
    step(2);
`ifdef BEAM_SCALERS_EN
    trig[NB+3] = 1'b1;
    step(100);
    trig = '0;
    step(3);
    check("scaler_100", 64'(scaler), 64'd100);
    trig[NB+3] = 1'b1;
    step(70000);
    check("scaler_sat", 64'(scaler), 64'hFFFF);
    saddr = 6'd63;
    step(2);
    check("scaler_oor", 64'(scaler), 64'd0);
    saddr = 6'd3;
    sclr = 1'b1; trig = '0;
    step();
    sclr = 1'b0;
    step();
    check("scaler_clr", 64'(scaler), 64'd0);
    check("scaler_no_event", 64'(valid), 64'd0);
`endif
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
